// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle RV32I datapath with a shared instruction/data
//   memory port. Each instruction (lw, sw, R-type, I-type ALU, beq, jal) is
//   broken into a per-cycle state sequence that drives the datapath muxes and
//   enables. Memory accesses may stall on mem_ready; an optional wait limit
//   aborts a stalled access back to FETCH.
//
//   State table (state | meaning):
//     FETCH    (0)  | read instruction at PC, PC <= PC + 4 on mem_ready
//     DECODE   (1)  | register read, branch target = OldPC + imm
//     MEMADR   (2)  | address = rs1 + imm for lw/sw
//     MEMREAD  (3)  | data read at computed address
//     MEMWB    (4)  | write loaded data to rd
//     MEMWRITE (5)  | store rs2 to computed address
//     EXECR    (6)  | R-type ALU operation
//     EXECI    (7)  | I-type ALU operation
//     JAL      (8)  | PC <= target, ALUOut <= OldPC + 4
//     ALUWB    (9)  | write ALUOut to rd
//     BEQ      (10) | compare rs1/rs2, PC <= target when zero
//
// Parameters:
//   MAX_WAIT  memory wait-cycle limit per access, 0 = unlimited
//   WAIT_W    wait counter width, MAX_WAIT < 2**WAIT_W
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   op                   opcode field of the instruction register
//   zero                 ALU zero flag
//   mem_ready            memory access completes this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write,
//   result_src, alu_src_a, alu_src_b, alu_op, imm_src
//                        datapath controls
//   illegal_op           pulse in DECODE on an unsupported opcode
//   mem_timeout          pulse when a memory wait hits MAX_WAIT
//   instr_done           pulse on the last cycle of a completed instruction
//   state                current state, for debug

module multicycle_controller #(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    JAL      = 4'd8,
    ALUWB    = 4'd9,
    BEQ      = 4'd10
  } stateT;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam bit              LIMITED  = (MAX_WAIT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  stateT             curState;
  stateT             nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic              inWaitState;
  logic              timeout;

  assign inWaitState = (curState == FETCH) || (curState == MEMREAD) ||
                       (curState == MEMWRITE);
  // mem_ready on the limit cycle is a normal completion, hence the !mem_ready.
  assign timeout = LIMITED && inWaitState && (waitCnt == WAIT_LIM) && !mem_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curState <= FETCH;
    end else begin
      curState <= nextState;
    end
  end

  // Wait counter: counts stalled cycles while a memory state holds; any
  // transition (including a timeout back into FETCH) restarts it from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (inWaitState && (nextState == curState) && !timeout) begin
      if (waitCnt != '1) begin
        waitCnt <= waitCnt + WAIT_W'(1);
      end
    end else begin
      waitCnt <= '0;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = FETCH;
    case (curState)
      FETCH: begin
        if (timeout)        nextState = FETCH;
        else if (mem_ready) nextState = DECODE;
        else                nextState = FETCH;
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXECR;
          OP_I:         nextState = EXECI;
          OP_JAL:       nextState = JAL;
          OP_BEQ:       nextState = BEQ;
          default:      nextState = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      nextState = MEMREAD;
        else if (op == OP_SW) nextState = MEMWRITE;
        else                  nextState = FETCH;
      end
      MEMREAD: begin
        if (timeout)        nextState = FETCH;
        else if (mem_ready) nextState = MEMWB;
        else                nextState = MEMREAD;
      end
      MEMWB:    nextState = FETCH;
      MEMWRITE: begin
        if (timeout || mem_ready) nextState = FETCH;
        else                      nextState = MEMWRITE;
      end
      EXECR:    nextState = ALUWB;
      EXECI:    nextState = ALUWB;
      JAL:      nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BEQ:      nextState = FETCH;
      default:  nextState = FETCH;
    endcase
  end

  // Output decode: Moore on state, except the strobes/pulses that need inputs
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    illegal_op  = 1'b0;
    mem_timeout = timeout;
    instr_done  = 1'b0;
    case (curState)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegal_op = 1'b0;
          default:                                  illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        // The strobe drops on the timeout cycle so an aborted store never lands.
        mem_write  = !timeout;
        instr_done = mem_ready;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      default: begin
        mem_timeout = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign state = curState;

endmodule
